control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/control_unit.sv | 192 +++++++++++++++++++
 tb/tb_control_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU: opcode values, controller state
// encoding and the bus multiplexer select codes. The ALU and datapath use
// the same package so that their op and select codes match the controller.
package cpu_pkg;

    // Opcodes, taken from instruction[7:4]. ADD..NOT double as ALU op codes.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_RD  = 4'h5;
    localparam logic [3:0] OP_WR  = 4'h6;
    localparam logic [3:0] OP_BR  = 4'h7;
    localparam logic [3:0] OP_BRZ = 4'h8;
    localparam logic [3:0] OP_BRO = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    // bus1 source select: 0-3 pick r0-r3, 4 picks the program counter.
    localparam logic [2:0] MUX1_PC = 3'd4;

    // bus2 source select.
    localparam logic [1:0] MUX2_ALU  = 2'd0;
    localparam logic [1:0] MUX2_BUS1 = 2'd1;
    localparam logic [1:0] MUX2_MEM  = 2'd2;

    // Two-operand ALU instructions need a second cycle (operand into Y first).
    function automatic logic is_alu2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 8-bit CPU. Walks each instruction
// through fetch, decode and execute states and drives the datapath
// register enables, bus source selects and memory write strobe.
//
// Ports:
//   clk, rst (async, active low)
//   instruction[7:0]  IR: [7:4] opcode, [3:2] src reg, [1:0] dest reg
//   zero, over        registered ALU flags, used by BRZ / BRO
//   load_r0..load_r3, load_pc, inc_pc, load_ir, load_a_reg,
//   load_reg_y, load_reg_z  datapath register enables
//   s_b_mux1[2:0]     bus1 source, s_b_mux2[1:0] bus2 source
//   write             memory write strobe, halted  high in S_HALT
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | after reset, nothing driven
// FET1   | pc -> a_reg (address of the opcode byte)
// FET2   | mem -> ir, pc++
// DEC    | decode; single-cycle ops finish here
// EX1    | second cycle of ADD/SUB/AND: alu -> dest, Z
// RD1/2  | fetch operand address, then mem -> dest
// WR1/2  | fetch operand address, then src -> mem
// BR1/2  | fetch target address, then load pc
// HALT   | stopped until reset
module control_unit
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic       zero,
    input  logic       over,
    output logic       load_r0,
    output logic       load_r1,
    output logic       load_r2,
    output logic       load_r3,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       load_ir,
    output logic       load_a_reg,
    output logic       load_reg_y,
    output logic       load_reg_z,
    output logic [2:0] s_b_mux1,
    output logic [1:0] s_b_mux2,
    output logic       write,
    output logic       halted
);

    state_t     state, state_next;
    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;
    logic [3:0] load_r;

    assign opcode = instruction[7:4];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    assign load_r0 = load_r[0];
    assign load_r1 = load_r[1];
    assign load_r2 = load_r[2];
    assign load_r3 = load_r[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_a_reg = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        s_b_mux1   = 3'd0;
        s_b_mux2   = MUX2_ALU;
        write      = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FET1;
            end
            S_FET1: begin
                s_b_mux1   = MUX1_PC;
                s_b_mux2   = MUX2_BUS1;
                load_a_reg = 1'b1;
                state_next = S_FET2;
            end
            S_FET2: begin
                s_b_mux2   = MUX2_MEM;
                load_ir    = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_DEC;
            end
            S_DEC: begin
                if (is_alu2(opcode)) begin
                    s_b_mux1   = {1'b0, src};
                    s_b_mux2   = MUX2_BUS1;
                    load_reg_y = 1'b1;
                    state_next = S_EX1;
                end else begin
                    case (opcode)
                        OP_NOP: state_next = S_FET1;
                        OP_NOT: begin
                            s_b_mux1     = {1'b0, src};
                            s_b_mux2     = MUX2_ALU;
                            load_r[dest] = 1'b1;
                            load_reg_z   = 1'b1;
                            state_next   = S_FET1;
                        end
                        OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BRO: begin
                            // Conditional branches that are not taken just
                            // step the pc over their operand byte.
                            if ((opcode == OP_BRZ && !zero) ||
                                (opcode == OP_BRO && !over)) begin
                                inc_pc     = 1'b1;
                                state_next = S_FET1;
                            end else begin
                                s_b_mux1   = MUX1_PC;
                                s_b_mux2   = MUX2_BUS1;
                                load_a_reg = 1'b1;
                                if (opcode == OP_RD) begin
                                    state_next = S_RD1;
                                end else if (opcode == OP_WR) begin
                                    state_next = S_WR1;
                                end else begin
                                    state_next = S_BR1;
                                end
                            end
                        end
                        OP_HLT: state_next = S_HALT;
                        default: state_next = HALT_ON_ILLEGAL ? S_HALT : S_FET1;
                    endcase
                end
            end
            S_EX1: begin
                s_b_mux1     = {1'b0, dest};
                s_b_mux2     = MUX2_ALU;
                load_r[dest] = 1'b1;
                load_reg_z   = 1'b1;
                state_next   = S_FET1;
            end
            S_RD1: begin
                s_b_mux2   = MUX2_MEM;
                load_a_reg = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_RD2;
            end
            S_RD2: begin
                s_b_mux2     = MUX2_MEM;
                load_r[dest] = 1'b1;
                state_next   = S_FET1;
            end
            S_WR1: begin
                s_b_mux2   = MUX2_MEM;
                load_a_reg = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_WR2;
            end
            S_WR2: begin
                s_b_mux1   = {1'b0, src};
                write      = 1'b1;
                state_next = S_FET1;
            end
            S_BR1: begin
                s_b_mux2   = MUX2_MEM;
                load_a_reg = 1'b1;
                state_next = S_BR2;
            end
            S_BR2: begin
                s_b_mux2   = MUX2_MEM;
                load_pc    = 1'b1;
                state_next = S_FET1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. Two instances share all inputs: dut_h halts on
// undefined opcodes (default), dut_n treats them as NOP. Each cycle the
// stimulus pushes the hand-derived expected output vector of both instances;
// a monitor pops and compares at the falling edge (or on demand right after
// an asynchronous reset).
// Vector layout: {r3,r2,r1,r0, load_pc, inc_pc, load_ir, load_a_reg,
//                 load_reg_y, load_reg_z, s_b_mux1[2:0], s_b_mux2[1:0],
//                 write, halted}
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic       over;

    logic       h_r0, h_r1, h_r2, h_r3, h_pc, h_inc, h_ir, h_a, h_y, h_z, h_wr, h_halt;
    logic [2:0] h_m1;
    logic [1:0] h_m2;
    logic       n_r0, n_r1, n_r2, n_r3, n_pc, n_inc, n_ir, n_a, n_y, n_z, n_wr, n_halt;
    logic [2:0] n_m1;
    logic [1:0] n_m2;

    logic [16:0] act_h, act_n;

    logic [16:0] q_h[$];
    logic [16:0] q_n[$];
    string       q_name[$];
    event        chk_now;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .over(over),
        .load_r0(h_r0), .load_r1(h_r1), .load_r2(h_r2), .load_r3(h_r3),
        .load_pc(h_pc), .inc_pc(h_inc), .load_ir(h_ir), .load_a_reg(h_a),
        .load_reg_y(h_y), .load_reg_z(h_z), .s_b_mux1(h_m1), .s_b_mux2(h_m2),
        .write(h_wr), .halted(h_halt)
    );

    control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .over(over),
        .load_r0(n_r0), .load_r1(n_r1), .load_r2(n_r2), .load_r3(n_r3),
        .load_pc(n_pc), .inc_pc(n_inc), .load_ir(n_ir), .load_a_reg(n_a),
        .load_reg_y(n_y), .load_reg_z(n_z), .s_b_mux1(n_m1), .s_b_mux2(n_m2),
        .write(n_wr), .halted(n_halt)
    );

    assign act_h = {h_r3, h_r2, h_r1, h_r0, h_pc, h_inc, h_ir, h_a, h_y, h_z,
                    h_m1, h_m2, h_wr, h_halt};
    assign act_n = {n_r3, n_r2, n_r1, n_r0, n_pc, n_inc, n_ir, n_a, n_y, n_z,
                    n_m1, n_m2, n_wr, n_halt};

    function automatic logic [16:0] ov(input logic [3:0] r, input logic pc,
                                       input logic inc, input logic ir,
                                       input logic a, input logic y,
                                       input logic z, input logic [2:0] m1,
                                       input logic [1:0] m2, input logic wr,
                                       input logic h);
        return {r, pc, inc, ir, a, y, z, m1, m2, wr, h};
    endfunction

    // Common expected vectors
    logic [16:0] v_zero, v_fet1, v_fet2, v_adec, v_skip, v_mem1, v_br1, v_br2, v_halt;

    initial begin
        v_zero = '0;
        v_fet1 = ov(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
        v_fet2 = ov(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
        v_adec = ov(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
        v_skip = ov(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0);
        v_mem1 = ov(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0);
        v_br1  = ov(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0);
        v_br2  = ov(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0);
        v_halt = ov(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1);
    end

    // Monitor / scoreboard
    initial begin
        logic [16:0] eh, en;
        string       nm;
        forever begin
            @(negedge clk or chk_now);
            if (q_h.size() > 0) begin
                eh = q_h.pop_front();
                en = q_n.pop_front();
                nm = q_name.pop_front();
                n_checks++;
                if (act_h !== eh) begin
                    n_fail++;
                    $display("FAIL %s (halt_on_illegal=1): got %05h want %05h", nm, act_h, eh);
                end
                n_checks++;
                if (act_n !== en) begin
                    n_fail++;
                    $display("FAIL %s (halt_on_illegal=0): got %05h want %05h", nm, act_n, en);
                end
            end
        end
    end

    task automatic push2(input string nm, input logic [16:0] eh, input logic [16:0] en);
        q_h.push_back(eh);
        q_n.push_back(en);
        q_name.push_back(nm);
    endtask

    task automatic step2(input string nm, input logic [16:0] eh, input logic [16:0] en);
        push2(nm, eh, en);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [16:0] e);
        step2(nm, e, e);
    endtask

    task automatic fetch(input logic [7:0] ir, input logic z, input logic o);
        instruction = ir;
        zero        = z;
        over        = o;
        step("fet1", v_fet1);
        step("fet2", v_fet2);
    endtask

    initial begin
        rst         = 1'b0;
        instruction = 8'h00;
        zero        = 1'b0;
        over        = 1'b0;
        @(posedge clk);
        #1;
        step("reset_low", v_zero);
        step("reset_low", v_zero);
        rst = 1'b1;
        step("idle_after_release", v_zero);

        // NOP: 3 cycles, inc_pc only in FET2
        fetch(8'h00, 0, 0);
        step("nop_dec", v_zero);

        // ADD r1 -> r2
        fetch(8'h16, 0, 0);
        step("add_dec", ov(4'b0000, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0));
        step("add_ex1", ov(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));

        // AND r2 -> r3
        fetch(8'h3B, 0, 0);
        step("and_dec", ov(4'b0000, 0, 0, 0, 0, 1, 0, 3'd2, 2'd1, 0, 0));
        step("and_ex1", ov(4'b1000, 0, 0, 0, 0, 0, 1, 3'd3, 2'd0, 0, 0));

        // NOT r1 -> r3, single cycle
        fetch(8'h47, 0, 0);
        step("not_dec", ov(4'b1000, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 0));

        // RD -> r3
        fetch(8'h53, 0, 0);
        step("rd_dec", v_adec);
        step("rd1", v_mem1);
        step("rd2", ov(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));

        // BRZ untaken then taken
        fetch(8'h80, 0, 0);
        step("brz_skip_dec", v_skip);
        fetch(8'h80, 1, 0);
        step("brz_taken_dec", v_adec);
        step("brz_br1", v_br1);
        step("brz_br2", v_br2);

        // BRO untaken then taken (zero set must not matter)
        fetch(8'h90, 1, 0);
        step("bro_skip_dec", v_skip);
        fetch(8'h90, 0, 1);
        step("bro_taken_dec", v_adec);
        step("bro_br1", v_br1);
        step("bro_br2", v_br2);

        // BR unconditional
        fetch(8'h70, 0, 0);
        step("br_dec", v_adec);
        step("br_br1", v_br1);
        step("br_br2", v_br2);

        // Undefined opcode: halt vs NOP
        fetch(8'hA0, 0, 0);
        step("illegal_dec", v_zero);
        step2("illegal_next", v_halt, v_fet1);
        step2("illegal_next", v_halt, v_fet2);
        step2("illegal_next", v_halt, v_zero);
        step2("illegal_next", v_halt, v_fet1);

        // Reset out of HALT, mid-cycle
        rst = 1'b0;
        step("reset_from_halt", v_zero);
        rst = 1'b1;
        step("idle_after_release2", v_zero);

        // WR r3, async reset during WR2
        fetch(8'h6C, 0, 0);
        step("wr_dec", v_adec);
        step("wr1", v_mem1);
        push2("wr2", ov(4'b0000, 0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 1, 0),
                     ov(4'b0000, 0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 1, 0));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        push2("async_reset_in_wr2", v_zero, v_zero);
        -> chk_now;
        @(posedge clk);
        #1;
        step("reset_held", v_zero);
        rst = 1'b1;
        step("idle_after_release3", v_zero);

        // HLT: halted indefinitely
        fetch(8'hF0, 0, 0);
        step("hlt_dec", v_zero);
        for (int i = 0; i < 5; i++) step("hlt_hold", v_halt);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q_h.size() > 0; i++) @(negedge clk);
        #1;
        if (q_h.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q_h.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
